// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, opcode encodings and the registered result word.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 z;
    logic                 n;
    logic                 c;
  } aluRes_t;

endpackage

// File: rtl/alu_result_mux_if.sv
// Unit-result inputs with upstream valid/ready, and registered result plus flags with downstream valid/ready.
// master drives operands and out_ready; slave is the result stage.
interface alu_result_mux_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
);
  logic [WIDTH-1:0] bigMuxIn0;
  logic [WIDTH-1:0] bigMuxIn1;
  logic [WIDTH-1:0] bigMuxIn2;
  logic [WIDTH-1:0] bigMuxIn3;
  logic [WIDTH-1:0] bigMuxIn4;
  logic [WIDTH-1:0] bigMuxIn5;
  logic [WIDTH-1:0] bigMuxIn6;
  logic [WIDTH-1:0] bigMuxIn7;
  logic [2:0]       sel;
  logic             carry_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output bigMuxIn0, bigMuxIn1, bigMuxIn2, bigMuxIn3,
    output bigMuxIn4, bigMuxIn5, bigMuxIn6, bigMuxIn7,
    output sel, carry_in, in_valid, out_ready,
    input  in_ready, result, flag_z, flag_n, flag_c, out_valid
  );

  modport slave (
    input  bigMuxIn0, bigMuxIn1, bigMuxIn2, bigMuxIn3,
    input  bigMuxIn4, bigMuxIn5, bigMuxIn6, bigMuxIn7,
    input  sel, carry_in, in_valid, out_ready,
    output in_ready, result, flag_z, flag_n, flag_c, out_valid
  );
endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer: 1-cycle latency, one word per cycle sustained.
// inReady comes straight from the skid-entry flop, so it never depends on outReady.
module alu_skid_buffer import alu_pkg::*; #(
  parameter type T = aluRes_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inValid,
  output logic inReady,
  input  T     inData,
  output logic outValid,
  input  logic outReady,
  output T     outData
);

  logic oValid;
  logic sValid;
  T     oData;
  T     sData;
  logic accept;
  logic xfer;

  assign inReady = !sValid;
  assign accept  = inValid && !sValid;
  assign xfer    = oValid && outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid <= 1'b0;
      sValid <= 1'b0;
      oData  <= '0;
      sData  <= '0;
    end else if (sValid) begin
      // A full skid entry implies a full output entry; only a drain can happen here.
      if (xfer) begin
        oData  <= sData;
        sValid <= 1'b0;
      end
    end else if (accept) begin
      if (!oValid || xfer) begin
        oData  <= inData;
        oValid <= 1'b1;
      end else begin
        sData  <= inData;
        sValid <= 1'b1;
      end
    end else if (xfer) begin
      oValid <= 1'b0;
    end
  end

  assign outValid = oValid;
  assign outData  = oData;

endmodule

// File: rtl/alu_result_mux.sv
// ALU output select: picks one unit result by opcode, derives Z/N/C and registers it.
// 1-cycle latency through a skid buffer; in_ready falls only once the skid entry is occupied.
module alu_result_mux import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_mux_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             z;
    logic             n;
    logic             c;
  } resWord_t;

  logic [WIDTH-1:0] selVal;
  resWord_t         nextWord;
  resWord_t         curWord;

  always_comb begin
    selVal = '0;
    case (bus.sel)
      OP_ADD:  selVal = bus.bigMuxIn0;
      OP_SUB:  selVal = bus.bigMuxIn1;
      OP_AND:  selVal = bus.bigMuxIn2;
      OP_XOR:  selVal = bus.bigMuxIn3;
      OP_OR:   selVal = bus.bigMuxIn4;
      OP_NOT:  selVal = bus.bigMuxIn5;
      OP_SHL:  selVal = bus.bigMuxIn6;
      OP_SHR:  selVal = bus.bigMuxIn7;
      default: selVal = '0;
    endcase
  end

  // Carry is only meaningful for the adder/subtractor results.
  always_comb begin
    nextWord      = '0;
    nextWord.data = selVal;
    nextWord.z    = (selVal == '0);
    nextWord.n    = selVal[WIDTH-1];
    nextWord.c    = ((bus.sel == OP_ADD) || (bus.sel == OP_SUB)) ? bus.carry_in : 1'b0;
  end

  alu_skid_buffer #(
    .T (resWord_t)
  ) uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (bus.in_valid),
    .inReady  (bus.in_ready),
    .inData   (nextWord),
    .outValid (bus.out_valid),
    .outReady (bus.out_ready),
    .outData  (curWord)
  );

  assign bus.result = curWord.data;
  assign bus.flag_z = curWord.z;
  assign bus.flag_n = curWord.n;
  assign bus.flag_c = curWord.c;

endmodule
